// File: rtl/pipeline_pkg.sv
// Shared constants and types for the IF/ID pipeline stage and its hazard logic.
package pipeline_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned OPC_W = 6;
  localparam int unsigned REG_W = 5;

  localparam logic [OPC_W-1:0] OP_RTYPE = 6'h00;
  localparam logic [OPC_W-1:0] OP_J     = 6'h02;
  localparam logic [OPC_W-1:0] OP_JAL   = 6'h03;
  localparam logic [OPC_W-1:0] OP_BEQZ  = 6'h04;
  localparam logic [OPC_W-1:0] OP_BNEZ  = 6'h05;
  localparam logic [OPC_W-1:0] OP_JR    = 6'h12;
  localparam logic [OPC_W-1:0] OP_JALR  = 6'h13;
  localparam logic [OPC_W-1:0] OP_SW    = 6'h2B;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    HALTED = 1'b1
  } state_e;

  // Upper half of an instruction word: the only fields hazard logic looks at.
  typedef struct packed {
    logic [OPC_W-1:0] opcode;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
  } id_fields_t;

  // r0 is hardwired to zero, so it can never be a true dependency.
  function automatic logic reg_match(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] rs);
    return (rd != REG_W'(0)) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use and register-branch hazard detection for the ID instruction.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic [15:0]      instr_hi,
  input  logic             reg_write_ex,
  input  logic             mem_read_ex,
  input  logic [REG_W-1:0] rd_ex,
  input  logic             mem_read_mem,
  input  logic [REG_W-1:0] rd_mem,
  output logic             load_use,
  output logic             branch_hazard,
  output logic             hazard
);

  id_fields_t f;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_branch_reg;

  // Decode source usage and flag producers still in flight.
  always_comb begin
    f             = id_fields_t'(instr_hi);
    uses_rs1      = 1'b1;
    uses_rs2      = 1'b0;
    is_branch_reg = 1'b0;
    load_use      = 1'b0;
    branch_hazard = 1'b0;

    if (f.opcode == OP_J || f.opcode == OP_JAL) uses_rs1 = 1'b0;
    if (f.opcode == OP_RTYPE || f.opcode == OP_SW) uses_rs2 = 1'b1;
    if (f.opcode == OP_BEQZ || f.opcode == OP_BNEZ ||
        f.opcode == OP_JR   || f.opcode == OP_JALR) is_branch_reg = 1'b1;

    load_use = mem_read_ex &&
               ((uses_rs1 && reg_match(rd_ex, f.rs1)) ||
                (uses_rs2 && reg_match(rd_ex, f.rs2)));

    // Branches resolve in ID, so they also wait on ALU results in EX and loads in MEM.
    branch_hazard = is_branch_reg &&
                    ((reg_write_ex && reg_match(rd_ex, f.rs1)) ||
                     (mem_read_mem && reg_match(rd_mem, f.rs1)));

    hazard = load_use || branch_hazard;
  end

endmodule

// File: rtl/pipeline_if_id.sv
// IF/ID pipeline register with flush, hazard stall, halt FSM and saturating stall counter.
module pipeline_if_id
  import pipeline_pkg::XLEN;
  import pipeline_pkg::REG_W;
  import pipeline_pkg::state_e;
  import pipeline_pkg::RUN;
  import pipeline_pkg::HALTED;
#(
  parameter logic [31:0] NOP_WORD = pipeline_pkg::NOP_WORD,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  instructionIf,
  input  logic [XLEN-1:0]  pcPlus4If,
  input  logic             branchTaken,
  input  logic             jumpTaken,
  input  logic             endProgram,
  input  logic             regWriteEx,
  input  logic             memReadEx,
  input  logic [REG_W-1:0] rdEx,
  input  logic             memReadMem,
  input  logic [REG_W-1:0] rdMem,
  output logic [XLEN-1:0]  instructionId,
  output logic [XLEN-1:0]  pcPlus4Id,
  output logic             validId,
  output logic             stall,
  output logic             bubbleEx,
  output logic             halted,
  output logic [CNT_W-1:0] stallCount
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e state;
  state_e state_next;
  logic   flush;
  logic   run;
  logic   hazard_raw;
  logic   hazard;
  logic   load_use;
  logic   branch_hazard;

  hazard_detect u_hazard_detect (
    .instr_hi      (instructionId[31:16]),
    .reg_write_ex  (regWriteEx),
    .mem_read_ex   (memReadEx),
    .rd_ex         (rdEx),
    .mem_read_mem  (memReadMem),
    .rd_mem        (rdMem),
    .load_use      (load_use),
    .branch_hazard (branch_hazard),
    .hazard        (hazard_raw)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // FSM next state: halt is suppressed when a redirect is in flight; only reset leaves HALTED.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (endProgram && !flush) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // FSM outputs and stall/bubble decode; a flush wins over a hazard.
  always_comb begin
    flush    = branchTaken || jumpTaken;
    run      = (state == RUN);
    halted   = (state == HALTED);
    hazard   = hazard_raw && validId && run;
    stall    = !run || (hazard && !flush);
    bubbleEx = stall || !validId;
  end

  // ID register: reset > halted hold > flush > hazard hold > normal load.
  always_ff @(posedge clk) begin
    if (reset) begin
      instructionId <= NOP_WORD;
      pcPlus4Id     <= '0;
      validId       <= 1'b0;
    end else if (!run) begin
      instructionId <= instructionId;
      pcPlus4Id     <= pcPlus4Id;
      validId       <= validId;
    end else if (flush) begin
      instructionId <= NOP_WORD;
      pcPlus4Id     <= pcPlus4If;
      validId       <= 1'b0;
    end else if (!hazard) begin
      instructionId <= instructionIf;
      pcPlus4Id     <= pcPlus4If;
      validId       <= 1'b1;
    end
  end

  // Saturating count of stall cycles spent in RUN.
  always_ff @(posedge clk) begin
    if (reset)                                   stallCount <= '0;
    else if (stall && run && stallCount != CNT_MAX) stallCount <= stallCount + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipeline_if_id.sv
// Directed table-driven bench for the IF/ID stage.
module tb_pipeline_if_id;

  localparam int unsigned CNT_W = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instructionIf, pcPlus4If;
  logic        branchTaken, jumpTaken, endProgram;
  logic        regWriteEx, memReadEx, memReadMem;
  logic [4:0]  rdEx, rdMem;
  logic [31:0] instructionId, pcPlus4Id;
  logic        validId, stall, bubbleEx, halted;
  logic [CNT_W-1:0] stallCount;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_if_id #(.NOP_WORD(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .instructionIf(instructionIf), .pcPlus4If(pcPlus4If),
    .branchTaken(branchTaken), .jumpTaken(jumpTaken), .endProgram(endProgram),
    .regWriteEx(regWriteEx), .memReadEx(memReadEx), .rdEx(rdEx),
    .memReadMem(memReadMem), .rdMem(rdMem),
    .instructionId(instructionId), .pcPlus4Id(pcPlus4Id), .validId(validId),
    .stall(stall), .bubbleEx(bubbleEx), .halted(halted), .stallCount(stallCount)
  );

  typedef struct {
    logic        rst;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        br, jmp, endp, rwex, mrex;
    logic [4:0]  rdex;
    logic        mrmem;
    logic [4:0]  rdmem;
    logic        cc;
    logic        e_stall, e_bub;
    logic [31:0] e_id, e_pc;
    logic        e_valid, e_halt;
    logic [CNT_W-1:0] e_cnt;
  } vec_t;

  // ADD r3,r1,r2 / ADD r4,r3,r3 / ADD r5,r2,r7 / ADD r6,r0,r0 / ADD r8,r9,r10
  localparam logic [31:0] I_A  = {6'h00, 5'd1, 5'd2, 5'd3, 11'd0};
  localparam logic [31:0] I_B  = {6'h00, 5'd3, 5'd3, 5'd4, 11'd0};
  localparam logic [31:0] I_C  = {6'h00, 5'd2, 5'd7, 5'd5, 11'd0};
  localparam logic [31:0] I_X  = {6'h00, 5'd0, 5'd0, 5'd6, 11'd0};
  localparam logic [31:0] I_Y  = {6'h00, 5'd9, 5'd10, 5'd8, 11'd0};
  localparam logic [31:0] I_Z  = {6'h00, 5'd11, 5'd12, 5'd13, 11'd0};
  localparam logic [31:0] I_BR = {6'h04, 5'd4, 5'd0, 16'h0010};
  localparam logic [31:0] I_JR = {6'h12, 5'd4, 5'd0, 16'h0000};
  localparam logic [31:0] I_J  = {6'h02, 5'd5, 21'd0};
  localparam logic [31:0] I_SW = {6'h2B, 5'd1, 5'd2, 16'h0008};
  localparam logic [31:0] I_LW = {6'h23, 5'd1, 5'd2, 16'h0000};

  function automatic vec_t mk(
    input logic rst, input logic [31:0] instr, input logic [31:0] pc,
    input logic br, input logic jmp, input logic endp,
    input logic rwex, input logic mrex, input logic [4:0] rdex,
    input logic mrmem, input logic [4:0] rdmem, input logic cc,
    input logic e_stall, input logic e_bub, input logic [31:0] e_id, input logic [31:0] e_pc,
    input logic e_valid, input logic e_halt, input logic [CNT_W-1:0] e_cnt);
    vec_t v;
    v.rst = rst; v.instr = instr; v.pc = pc; v.br = br; v.jmp = jmp; v.endp = endp;
    v.rwex = rwex; v.mrex = mrex; v.rdex = rdex; v.mrmem = mrmem; v.rdmem = rdmem;
    v.cc = cc; v.e_stall = e_stall; v.e_bub = e_bub; v.e_id = e_id; v.e_pc = e_pc;
    v.e_valid = e_valid; v.e_halt = e_halt; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive on the falling edge, check combinational outputs, then registered outputs after the edge.
  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    reset = v.rst; instructionIf = v.instr; pcPlus4If = v.pc;
    branchTaken = v.br; jumpTaken = v.jmp; endProgram = v.endp;
    regWriteEx = v.rwex; memReadEx = v.mrex; rdEx = v.rdex;
    memReadMem = v.mrmem; rdMem = v.rdmem;
    #1;
    if (v.cc) begin
      chk("stall", idx, 32'(stall), 32'(v.e_stall));
      chk("bubbleEx", idx, 32'(bubbleEx), 32'(v.e_bub));
    end
    @(posedge clk);
    #1;
    chk("instructionId", idx, instructionId, v.e_id);
    chk("pcPlus4Id", idx, pcPlus4Id, v.e_pc);
    chk("validId", idx, 32'(validId), 32'(v.e_valid));
    chk("halted", idx, 32'(halted), 32'(v.e_halt));
    chk("stallCount", idx, 32'(stallCount), 32'(v.e_cnt));
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1'b1; instructionIf = '0; pcPlus4If = '0; branchTaken = 1'b0; jumpTaken = 1'b0;
    endProgram = 1'b0; regWriteEx = 1'b0; memReadEx = 1'b0; rdEx = '0; memReadMem = 1'b0; rdMem = '0;

    // reset, streaming, load-use, r0, load-branch, flush priority, opcode usage
    vecs.push_back(mk(1, I_A, 32'h100, 0,0,0, 0,0,0, 0,0, 0, 0,0, 32'h0, 32'h0, 0,0,0));
    vecs.push_back(mk(1, I_A, 32'h100, 0,0,0, 0,0,0, 0,0, 1, 0,1, 32'h0, 32'h0, 0,0,0));
    vecs.push_back(mk(0, I_A,  32'h104, 0,0,0, 0,0,0, 0,0, 1, 0,1, I_A,  32'h104, 1,0,0));
    vecs.push_back(mk(0, I_B,  32'h108, 0,0,0, 1,0,3, 0,0, 1, 0,0, I_B,  32'h108, 1,0,0));
    vecs.push_back(mk(0, I_C,  32'h10C, 0,0,0, 0,0,0, 0,0, 1, 0,0, I_C,  32'h10C, 1,0,0));
    vecs.push_back(mk(0, I_X,  32'h110, 0,0,0, 1,1,7, 0,0, 1, 1,1, I_C,  32'h10C, 1,0,1));
    vecs.push_back(mk(0, I_X,  32'h110, 0,0,0, 0,0,0, 1,7, 1, 0,0, I_X,  32'h110, 1,0,1));
    vecs.push_back(mk(0, I_BR, 32'h114, 0,0,0, 1,1,0, 0,0, 1, 0,0, I_BR, 32'h114, 1,0,1));
    vecs.push_back(mk(0, I_Y,  32'h118, 0,0,0, 1,1,4, 0,0, 1, 1,1, I_BR, 32'h114, 1,0,2));
    vecs.push_back(mk(0, I_Y,  32'h118, 0,0,0, 0,0,0, 1,4, 1, 1,1, I_BR, 32'h114, 1,0,3));
    vecs.push_back(mk(0, I_Y,  32'h118, 0,0,0, 0,0,0, 0,0, 1, 0,0, I_Y,  32'h118, 1,0,3));
    vecs.push_back(mk(0, I_Z,  32'h11C, 0,1,0, 0,1,9, 0,0, 1, 0,0, 32'h0, 32'h11C, 0,0,3));
    vecs.push_back(mk(0, I_Y,  32'h120, 0,0,0, 0,1,9, 0,0, 1, 0,1, I_Y,  32'h120, 1,0,3));
    vecs.push_back(mk(0, I_A,  32'h124, 1,0,0, 0,0,0, 0,0, 1, 0,0, 32'h0, 32'h124, 0,0,3));
    vecs.push_back(mk(0, I_JR, 32'h128, 0,0,0, 0,0,0, 0,0, 1, 0,1, I_JR, 32'h128, 1,0,3));
    vecs.push_back(mk(0, I_A,  32'h12C, 0,0,0, 1,0,4, 0,0, 1, 1,1, I_JR, 32'h128, 1,0,4));
    vecs.push_back(mk(0, I_A,  32'h12C, 0,0,0, 0,0,0, 0,0, 1, 0,0, I_A,  32'h12C, 1,0,4));
    vecs.push_back(mk(0, I_J,  32'h130, 0,0,0, 0,0,0, 0,0, 1, 0,0, I_J,  32'h130, 1,0,4));
    vecs.push_back(mk(0, I_SW, 32'h134, 0,0,0, 0,1,5, 0,0, 1, 0,0, I_SW, 32'h134, 1,0,4));
    vecs.push_back(mk(0, I_A,  32'h138, 0,0,0, 0,1,2, 0,0, 1, 1,1, I_SW, 32'h134, 1,0,5));
    vecs.push_back(mk(0, I_LW, 32'h13C, 0,0,0, 0,0,0, 0,0, 1, 0,0, I_LW, 32'h13C, 1,0,5));
    vecs.push_back(mk(0, I_A,  32'h140, 0,0,0, 0,1,2, 0,0, 1, 0,0, I_A,  32'h140, 1,0,5));
    vecs.push_back(mk(0, I_B,  32'h144, 0,1,1, 0,0,0, 0,0, 1, 0,0, 32'h0, 32'h144, 0,0,5));

    foreach (vecs[i]) apply(vecs[i], i);

    // halt: the halting edge still loads, then everything freezes
    apply(mk(0, I_A, 32'h148, 0,0,1, 0,0,0, 0,0, 1, 0,1, I_A, 32'h148, 1,1,5), 100);
    for (int k = 0; k < 10; k++) begin
      apply(mk(0, $urandom, $urandom, 1'(k & 1), 1'((k >> 1) & 1), 1'((k >> 2) & 1),
               1,1,1, 1,1, 1, 1,1, I_A, 32'h148, 1,1,5), 101 + k);
    end

    // reset out of HALTED, then reset in the middle of a hazard stall
    apply(mk(1, I_B, 32'h0,   0,0,0, 0,0,0, 0,0, 1, 1,1, 32'h0, 32'h0, 0,0,0), 200);
    apply(mk(0, I_C, 32'h200, 0,0,0, 0,0,0, 0,0, 1, 0,1, I_C, 32'h200, 1,0,0), 201);
    apply(mk(1, I_B, 32'h999, 0,0,1, 0,1,7, 0,0, 1, 1,1, 32'h0, 32'h0, 0,0,0), 202);
    apply(mk(0, I_C, 32'h204, 0,0,0, 0,1,7, 0,0, 1, 0,1, I_C, 32'h204, 1,0,0), 203);

    // counter saturation under a long stall
    for (int k = 1; k <= 20; k++) begin
      apply(mk(0, I_B, 32'h300, 0,0,0, 0,1,7, 0,0, 1, 1,1, I_C, 32'h204, 1,0,
               CNT_W'((k > 15) ? 15 : k)), 300 + k);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_if_id.md
PIPELINE_IF_ID -- requirements
Module: pipeline_if_id

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter NOP_WORD, default 32'h00000000, is the instruction word injected on flush or bubble.
REQ-003 Parameter CNT_W, default 16, is the stall-counter width.
REQ-004 Port list, one per line (name  direction  width  meaning):
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- instructionIf  in  32  word fetched this cycle
- pcPlus4If  in  32  fetch PC+4
- branchTaken  in  1  fetch-stage branch redirect this cycle
- jumpTaken  in  1  jump or jump-register redirect this cycle
- endProgram  in  1  fetch halt detect
- regWriteEx  in  1  EX-stage instruction writes a register
- memReadEx  in  1  EX-stage instruction is a load
- rdEx  in  5  EX destination register
- memReadMem  in  1  MEM-stage instruction is a load
- rdMem  in  5  MEM destination register
- instructionId  out  32  registered ID instruction
- pcPlus4Id  out  32  registered ID PC+4
- validId  out  1  ID holds a real instruction
- stall  out  1  combinational; fetch holds the PC
- bubbleEx  out  1  combinational; ID/EX loads a NOP
- halted  out  1  HALTED state flag
- stallCount  out  CNT_W  saturating count of stall cycles

Function
REQ-010 Field decode SHALL use opcode [31:26], rs1 [25:21] and rs2 [20:16].
REQ-011 usesRs1 SHALL be 1 unless opcode is 6'h02 (J) or 6'h03 (JAL).
REQ-012 usesRs2 SHALL be 1 only for opcode 6'h00 (R-type) or 6'h2B (SW).
REQ-013 isBranchReg SHALL be 1 for opcode 6'h04, 6'h05, 6'h12 or 6'h13.
REQ-014 A register match SHALL require a nonzero index; r0 never hazards.
REQ-015 Load-use hazard: memReadEx is 1 and rdEx matches a used rs1 or rs2 of instructionId.
REQ-016 Branch hazard: isBranchReg is 1, and either regWriteEx is 1 with rdEx == rs1, or memReadMem is 1 with rdMem == rs1.
REQ-017 hazard = (load-use OR branch hazard) AND validId AND state==RUN.
REQ-018 FSM states SHALL be RUN and HALTED.
- RUN -> HALTED when endProgram=1 at a clock edge and no flush is pending.
- HALTED -> RUN only on reset.
REQ-019 Priority each edge SHALL be: reset > HALTED hold > flush (branchTaken OR jumpTaken) > hazard hold > normal load.
REQ-020 Flush: load NOP_WORD and validId=0; pcPlus4Id is don't-care but SHALL be loaded from pcPlus4If; stall=0 in that cycle even if a hazard exists.
REQ-021 Hazard hold: instructionId, pcPlus4Id and validId keep their values; stall=1 and bubbleEx=1 in the same cycle.
REQ-022 Normal load: take instructionIf and pcPlus4If; validId=1.
REQ-023 Latency SHALL be one cycle from fetch to ID outputs.
REQ-024 A load feeding a branch SHALL naturally yield 2 stall cycles (EX then MEM match); no extra state is needed.
REQ-025 In HALTED, all ID registers freeze, stall=1, bubbleEx=1 and halted=1.
REQ-026 stallCount SHALL increment on each edge where stall=1 and state==RUN, and saturate at all-ones (no wrap).
REQ-027 bubbleEx SHALL be 1 whenever validId=0 (a flushed slot drains as a NOP).

Reset
REQ-030 On reset, the block SHALL set instructionId=NOP_WORD, pcPlus4Id=0, validId=0, state=RUN, halted=0 and stallCount=0.
REQ-031 Reset SHALL override flush, hazard and endProgram in the same cycle.
REQ-032 Reset asserted mid-stall or in HALTED SHALL return the block to RUN on the next edge.

Structure
REQ-040 Opcode constants (J, JAL, BEQZ, BNEZ, JR, JALR, RTYPE, SW), NOP_WORD and the state encoding SHALL live in the shared package pipeline_pkg.
REQ-041 Hazard detection SHALL be one combinational sub-module, hazard_detect, reused by later forwarding work.
REQ-042 Registers, FSM and counter SHALL live in pipeline_if_id.

Verification
REQ-050 Stream: after reset, ADD r3,r1,r2 then ADD r4,r3,r3 with no EX load -> no stall, both reach ID on consecutive cycles, stallCount=0.
REQ-051 Load-use: ID=ADD r5,r2,r7, memReadEx=1, rdEx=7 -> stall=1 and bubbleEx=1 for exactly 1 cycle; ID holds; stallCount=1.
REQ-052 Load-branch: ID=BEQZ r4, load to r4 enters EX then MEM -> stall asserted 2 cycles; the branch is released on cycle 3.
REQ-053 Flush priority: jumpTaken=1 while a hazard condition is true -> stall=0, instructionId=32'h00000000, validId=0 next cycle.
REQ-054 Halt: endProgram=1 -> halted=1 next cycle; instructionId frozen across 10 cycles; stallCount stays fixed.
REQ-055 Reset corner cases:
- reset during a hazard stall -> all REQ-030 values next cycle.
- r0-only dependency (rdEx=0) -> never stalls.
